bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 147 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Burst reader: takes a (start address, length) request, streams words out of a
// one-cycle-latency BRAM with wrap-around addressing through a 2-entry skid FIFO.
module bram_stream_reader #(
  parameter  int BRAM_DEPTH = 10,
  parameter  int BRAM_W     = 64,
  localparam int AW         = $clog2(BRAM_DEPTH),
  localparam int LW         = $clog2(BRAM_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AW-1:0]     req_addr_i,
  input  logic [LW-1:0]     req_len_i,
  output logic [AW-1:0]     mem_raddr_o,
  input  logic [BRAM_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BRAM_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [LW-1:0]       rem_q, rem_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  // Head entry is the output register; tail catches a word while the head stalls.
  logic                head_v_q, head_v_d;
  logic                head_l_q, head_l_d;
  logic [BRAM_W-1:0]   head_d_q, head_d_d;
  logic                tail_v_q, tail_v_d;
  logic                tail_l_q, tail_l_d;
  logic [BRAM_W-1:0]   tail_d_q, tail_d_d;

  logic                pop;
  logic [1:0]          occupancy;
  logic                issue;

  assign pop       = head_v_q & out_ready_i;
  assign occupancy = 2'(head_v_q) + 2'(tail_v_q) + 2'(inflight_q);
  // An issued word lands two edges later; only issue if a slot is guaranteed.
  assign issue     = (state_q == RUN) && ((occupancy - 2'(pop)) <= 2'd1);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d         = state_q;
    raddr_d         = raddr_q;
    rem_d           = rem_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    head_v_d        = head_v_q;
    head_l_d        = head_l_q;
    head_d_d        = head_d_q;
    tail_v_d        = tail_v_q;
    tail_l_d        = tail_l_q;
    tail_d_d        = tail_d_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && (req_len_i != '0)) begin
          state_d = RUN;
          raddr_d = req_addr_i;
          rem_d   = req_len_i;
        end
      end
      RUN: begin
        if (issue) begin
          inflight_d      = 1'b1;
          inflight_last_d = (rem_q == LW'(1));
          raddr_d         = (raddr_q == AW'(BRAM_DEPTH - 1)) ? '0 : raddr_q + 1'b1;
          rem_d           = rem_q - 1'b1;
          if (rem_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_l_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      if (tail_v_q) begin
        head_v_d = 1'b1;
        head_l_d = tail_l_q;
        head_d_d = tail_d_q;
        tail_v_d = 1'b0;
      end else begin
        head_v_d = 1'b0;
      end
    end

    if (inflight_q) begin
      if (!head_v_d) begin
        head_v_d = 1'b1;
        head_l_d = inflight_last_q;
        head_d_d = mem_rdata_i;
      end else begin
        tail_v_d = 1'b1;
        tail_l_d = inflight_last_q;
        tail_d_d = mem_rdata_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      raddr_q         <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_v_q        <= 1'b0;
      head_l_q        <= 1'b0;
      head_d_q        <= '0;
      tail_v_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_v_q        <= head_v_d;
      head_l_q        <= head_l_d;
      head_d_q        <= head_d_d;
      tail_v_q        <= tail_v_d;
    end
  end

  // NOTE: tail payload is qualified by tail_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_l_q <= tail_l_d;
    tail_d_q <= tail_d_d;
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign mem_raddr_o = raddr_q;
  assign out_valid_o = head_v_q;
  assign out_data_o  = head_d_q;
  assign out_last_o  = head_l_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: directed bursts plus random bursts
// with random back-pressure, compared against words read straight from the memory array.
module tb_bram_stream_reader;
  localparam int DEPTH = 16;
  localparam int W     = 64;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [AW-1:0] mem_raddr;
  logic [W-1:0]  mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;

  logic [W-1:0]  mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;

  bram_stream_reader #(.BRAM_DEPTH(DEPTH), .BRAM_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .mem_raddr_o (mem_raddr),
    .mem_rdata_i (mem_rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Registered-read memory: data for the address seen at an edge is valid after it.
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_raddr",     mem_raddr, 0);
    check("rst_busy",      busy,      0);
    check("rst_req_ready", req_ready, 1);
  endtask

  // mode 0: ready always high; 1: low 5 cycles then 1,0,1,0...; 2: random ready.
  // abort_after > 0 returns right after that many beats have transferred.
  task automatic run_burst(input int addr, input int len, input int mode, input int abort_after);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pd;
    logic         pl;
    bit           stalled;
    int           k, c, first_c, last_c, off;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr + i) % DEPTH]);
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    check("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("busy_after_accept", busy, (len > 0));
    if (len == 0) begin
      for (int i = 0; i < 4; i++) begin
        check("len0_no_valid", out_valid, 0);
        check("len0_busy", busy, 0);
        check("len0_req_ready", req_ready, 1);
        tick();
      end
      return;
    end
    k = 0; c = 0; first_c = -1; last_c = -1; stalled = 0; pd = '0; pl = 1'b0;
    while (k < len && c < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c < 5) ? 1'b0 : (((c - 5) % 2) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 0 && c <= len) check("raddr_seq", mem_raddr, (addr + c) % DEPTH);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_last", out_last, pl);
      end
      if (mode != 0) begin
        off = (int'(mem_raddr) - addr + DEPTH) % DEPTH;
        check("raddr_lead_le2", (off - k) <= 2, 1);
      end
      if (out_valid && first_c < 0) first_c = c;
      if (out_valid && out_ready) begin
        check("beat_data", out_data, exp_q[k]);
        check("beat_last", out_last, (k == len - 1));
        last_c  = c;
        k++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        pd      = out_data;
        pl      = out_last;
      end
      tick();
      c++;
      if (abort_after > 0 && k == abort_after) return;
    end
    check("burst_complete", k, len);
    if (mode == 0) begin
      check("first_beat_latency", first_c, 2);
      check("no_bubbles", last_c, len + 1);
    end
    out_ready = 1'($urandom_range(0, 1));
    check("busy_done", busy, 0);
    check("idle_no_valid", out_valid, 0);
    check("req_ready_done", req_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'(i * 'h11);
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    run_burst(3, 4, 0, 0);
    run_burst(14, 4, 0, 0);
    run_burst(0, 8, 1, 0);
    run_burst(0, 0, 0, 0);
    run_burst(5, 1, 0, 0);

    // Mid-burst reset: no stale beat may surface afterwards.
    run_burst(0, 16, 0, 2);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    run_burst(2, 2, 0, 0);
    run_burst(0, 16, 0, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    for (int n = 0; n < 30; n++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                ($urandom_range(0, 3) == 0) ? 0 : 2, 0);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
